// File: rtl/frame_writer_if.sv
// Camera capture inputs and frame-buffer write port shared between the frame
// writer (master) and its environment (slave).
interface frame_writer_if #(
  parameter int ADDR_W = 18
);
   logic              vsync;
   logic              href;
   logic [31:0]       pix_data;
   logic              pix_done;
   logic [ADDR_W-1:0] bram_addr;
   logic [15:0]       bram_din;
   logic              bram_we;

   modport master (
      input  vsync, href, pix_data, pix_done,
      output bram_addr, bram_din, bram_we
   );

   modport slave (
      output vsync, href, pix_data, pix_done,
      input  bram_addr, bram_din, bram_we
   );
endinterface

// File: rtl/frame_writer.sv
// Captures YCbCr422 luma pairs into a frame buffer and tracks the brightest
// above-threshold pixel per vsync-bracketed frame.
module frame_writer #(
   parameter int H_PAIRS = 320,
   parameter int V_LINES = 480,
   parameter int ADDR_W  = 18
) (
   input  logic                pclk,
   input  logic                reset,
   frame_writer_if.master      bus,
   input  logic [7:0]          threshold,
   output logic [9:0]          spot_x,
   output logic [8:0]          spot_y,
   output logic [7:0]          spot_luma,
   output logic                spot_found,
   output logic                spot_valid,
   output logic [7:0]          frame_count,
   output logic                overflow,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      ARMED     = 2'd1,
      CAPTURE   = 2'd2,
      DONE      = 2'd3
   } state_t;

   localparam logic [9:0] H_LIM = 10'(H_PAIRS);
   localparam logic [8:0] V_LIM = 9'(V_LINES);

   state_t state, state_n;

   logic              pix_done_d;
   logic              href_d;
   logic [9:0]        col;
   logic [8:0]        row;
   logic [ADDR_W-1:0] addr_cnt;
   logic              best_valid;
   logic [7:0]        best_luma;
   logic [9:0]        best_x;
   logic [8:0]        best_y;

   logic              strobe, href_fall, take, in_range, accept;
   logic [7:0]        y0, y1, cand_luma;
   logic              odd;
   logic [9:0]        cand_x;
   logic              better;

   // Chroma bytes are not stored; the top column bit never reaches x.
   logic unused_bits;
   assign unused_bits = ^{bus.pix_data[23:8], col[9]};

   assign strobe    = bus.pix_done & ~pix_done_d;
   assign href_fall = href_d & ~bus.href;
   // A strobe landing on the href falling-edge cycle still belongs to the line.
   assign take      = (state == CAPTURE) & strobe & (bus.href | href_fall);
   assign in_range  = (col < H_LIM) && (row < V_LIM);
   assign accept    = take & in_range;

   assign y0        = bus.pix_data[31:24];
   assign y1        = bus.pix_data[7:0];
   assign odd       = (y1 > y0);
   assign cand_luma = odd ? y1 : y0;
   assign cand_x    = {col[8:0], odd};
   assign better    = (cand_luma >= threshold) &&
                      (!best_valid || (cand_luma > best_luma));

   assign state_dbg = state;

   always_ff @(posedge pclk) begin
      if (reset) state <= WAIT_SYNC;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         WAIT_SYNC: if (bus.vsync)  state_n = ARMED;
         ARMED:     if (!bus.vsync) state_n = CAPTURE;
         CAPTURE:   if (bus.vsync)  state_n = DONE;
         DONE:                      state_n = ARMED;
         default:                   state_n = WAIT_SYNC;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         pix_done_d    <= 1'b0;
         href_d        <= 1'b0;
         col           <= '0;
         row           <= '0;
         addr_cnt      <= '0;
         best_valid    <= 1'b0;
         best_luma     <= '0;
         best_x        <= '0;
         best_y        <= '0;
         bus.bram_we   <= 1'b0;
         bus.bram_addr <= '0;
         bus.bram_din  <= '0;
         spot_x        <= '0;
         spot_y        <= '0;
         spot_luma     <= '0;
         spot_found    <= 1'b0;
         spot_valid    <= 1'b0;
         frame_count   <= '0;
         overflow      <= 1'b0;
      end else begin
         pix_done_d  <= bus.pix_done;
         href_d      <= bus.href;
         bus.bram_we <= 1'b0;
         spot_valid  <= 1'b0;

         if (state == CAPTURE) begin
            if (accept) begin
               bus.bram_we   <= 1'b1;
               bus.bram_addr <= addr_cnt;
               bus.bram_din  <= {y0, y1};
               addr_cnt      <= addr_cnt + 1'b1;
               col           <= col + 10'd1;
               if (better) begin
                  best_valid <= 1'b1;
                  best_luma  <= cand_luma;
                  best_x     <= cand_x;
                  best_y     <= row;
               end
            end else if (take) begin
               overflow <= 1'b1;
            end

            // Empty lines do not advance the row; row saturates at the limit.
            if (href_fall) begin
               col <= '0;
               if (((col != 10'd0) || accept) && (row < V_LIM))
                  row <= row + 9'd1;
            end
         end else begin
            col        <= '0;
            row        <= '0;
            addr_cnt   <= '0;
            best_valid <= 1'b0;
            best_luma  <= '0;
            best_x     <= '0;
            best_y     <= '0;
            if (state == DONE) begin
               spot_x      <= best_x;
               spot_y      <= best_y;
               spot_luma   <= best_luma;
               spot_found  <= best_valid;
               spot_valid  <= 1'b1;
               frame_count <= frame_count + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with a small 4x2 frame; expected writes and
// frame results are queued and checked by an independent output monitor.
module tb_frame_writer;

   localparam int H_PAIRS = 4;
   localparam int V_LINES = 2;
   localparam int ADDR_W  = 18;

   logic              pclk;
   logic              reset;
   logic [7:0]        threshold;
   logic [9:0]        spot_x;
   logic [8:0]        spot_y;
   logic [7:0]        spot_luma;
   logic              spot_found;
   logic              spot_valid;
   logic [7:0]        frame_count;
   logic              overflow;
   logic [1:0]        state_dbg;

   frame_writer_if #(.ADDR_W(ADDR_W)) bus ();

   frame_writer #(.H_PAIRS(H_PAIRS), .V_LINES(V_LINES), .ADDR_W(ADDR_W)) dut (
      .pclk        (pclk),
      .reset       (reset),
      .bus         (bus),
      .threshold   (threshold),
      .spot_x      (spot_x),
      .spot_y      (spot_y),
      .spot_luma   (spot_luma),
      .spot_found  (spot_found),
      .spot_valid  (spot_valid),
      .frame_count (frame_count),
      .overflow    (overflow),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_checks = 0;
   int n_fail   = 0;

   // {addr, din} per write; {x, y, luma, found, frame_count} per frame
   logic [ADDR_W+15:0] exp_q[$];
   logic [35:0]        exp_spot_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [35:0] spot_exp(input logic [9:0] x, input logic [8:0] y,
                                            input logic [7:0] l, input logic f,
                                            input logic [7:0] fc);
      return {x, y, l, f, fc};
   endfunction

   // monitor / scoreboard
   always @(negedge pclk) begin
      if (bus.bram_we) begin
         if (exp_q.size() == 0) check("unexpected_write", {bus.bram_addr, bus.bram_din}, 64'hdead);
         else check("write", {bus.bram_addr, bus.bram_din}, exp_q.pop_front());
      end
      if (spot_valid) begin
         if (exp_spot_q.size() == 0)
            check("unexpected_spot", {spot_x, spot_y, spot_luma, spot_found, frame_count}, 64'hdead);
         else
            check("spot", {spot_x, spot_y, spot_luma, spot_found, frame_count}, exp_spot_q.pop_front());
      end
   end

   // driver tasks
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic send_pair(input logic [31:0] d, input int hold);
      bus.pix_data = d;
      bus.pix_done = 1'b1;
      cyc(hold);
      bus.pix_done = 1'b0;
      cyc(1);
   endtask

   task automatic wr(input int addr, input logic [15:0] din);
      exp_q.push_back({ADDR_W'(addr), din});
   endtask

   task automatic line_start();
      bus.href = 1'b1;
      cyc(1);
   endtask

   task automatic line_end();
      bus.href = 1'b0;
      cyc(2);
   endtask

   task automatic boundary();
      bus.vsync = 1'b1;
      cyc(2);
      bus.vsync = 1'b0;
      cyc(2);
   endtask

   initial begin
      reset        = 1'b1;
      threshold    = 8'h80;
      bus.vsync    = 1'b0;
      bus.href     = 1'b0;
      bus.pix_data = '0;
      bus.pix_done = 1'b0;
      cyc(3);
      check("rst_state",    state_dbg,   2'd0);
      check("rst_we",       bus.bram_we, 1'b0);
      check("rst_addr",     bus.bram_addr, '0);
      check("rst_fcount",   frame_count, 8'd0);
      check("rst_overflow", overflow,    1'b0);
      check("rst_spot",     {spot_x, spot_y, spot_luma, spot_found, spot_valid}, '0);
      reset = 1'b0;
      cyc(1);

      // strobe before any vsync bracket is ignored
      line_start();
      send_pair(32'hFF0000FF, 1);
      line_end();

      // frame 1: all Y=0x10, no candidate
      boundary();
      for (int r = 0; r < 2; r++) begin
         line_start();
         for (int c = 0; c < 4; c++) begin
            wr(r * 4 + c, 16'h1010);
            send_pair(32'h10808010, 1);
         end
         line_end();
      end
      exp_spot_q.push_back(spot_exp(0, 0, 0, 0, 1));

      // frame 2: pix_done held three cycles gives one write
      boundary();
      line_start();
      wr(0, 16'h2030);
      send_pair(32'h20808030, 3);
      line_end();
      exp_spot_q.push_back(spot_exp(0, 0, 0, 0, 2));

      // frame 3: bright pair at row 1 col 2, odd pixel wins; href-low strobe ignored
      boundary();
      line_start();
      for (int c = 0; c < 4; c++) begin
         wr(c, 16'h0000);
         send_pair(32'h00000000, 1);
      end
      line_end();
      send_pair(32'hFF0000FF, 1);
      line_start();
      wr(4, 16'h0000); send_pair(32'h00000000, 1);
      wr(5, 16'h0000); send_pair(32'h00000000, 1);
      wr(6, 16'h90F0); send_pair(32'h908080F0, 1);
      wr(7, 16'h5050); send_pair(32'h50808050, 1);
      line_end();
      exp_spot_q.push_back(spot_exp(5, 1, 8'hF0, 1, 3));

      // frame 4: equal luma at (0,0) and (1,3), first wins
      boundary();
      line_start();
      wr(0, 16'hC0C0); send_pair(32'hC08080C0, 1);
      for (int c = 1; c < 4; c++) begin
         wr(c, 16'h0000);
         send_pair(32'h00000000, 1);
      end
      line_end();
      line_start();
      for (int c = 0; c < 3; c++) begin
         wr(4 + c, 16'h0000);
         send_pair(32'h00000000, 1);
      end
      wr(7, 16'hC0C0); send_pair(32'hC08080C0, 1);
      line_end();
      exp_spot_q.push_back(spot_exp(0, 0, 8'hC0, 1, 4));
      check("no_overflow_yet", overflow, 1'b0);

      // frame 5: five pairs on a four-pair line
      boundary();
      line_start();
      for (int c = 0; c < 4; c++) begin
         wr(c, 16'h0505);
         send_pair(32'h05808005, 1);
      end
      send_pair(32'h05808005, 1);
      line_end();
      check("overflow_set", overflow, 1'b1);
      line_start();
      wr(4, 16'h0606); send_pair(32'h06808006, 1);
      line_end();
      exp_spot_q.push_back(spot_exp(0, 0, 0, 0, 5));

      // frame 6: overflow stays sticky
      boundary();
      check("overflow_sticky", overflow, 1'b1);
      line_start();
      wr(0, 16'h0707); send_pair(32'h07808007, 1);
      line_end();
      exp_spot_q.push_back(spot_exp(0, 0, 0, 0, 6));

      // frame 7: reset mid-line abandons the frame
      boundary();
      line_start();
      wr(0, 16'hE0E0); send_pair(32'hE08080E0, 1);
      wr(1, 16'hE1E1); send_pair(32'hE18080E1, 1);
      reset = 1'b1;
      cyc(2);
      reset = 1'b0;
      check("midrst_state",    state_dbg,   2'd0);
      check("midrst_overflow", overflow,    1'b0);
      check("midrst_fcount",   frame_count, 8'd0);
      check("midrst_found",    spot_found,  1'b0);
      send_pair(32'hFF0000FF, 1);
      line_end();

      // fresh bracket after reset restarts at address 0
      boundary();
      line_start();
      wr(0, 16'h90A0); send_pair(32'h901122A0, 1);
      wr(1, 16'h8520); send_pair(32'h85112220, 1);
      line_end();
      exp_spot_q.push_back(spot_exp(1, 0, 8'hA0, 1, 1));
      bus.vsync = 1'b1;
      cyc(3);
      bus.vsync = 1'b0;
      cyc(5);

      // final report
      check("writes_drained", exp_q.size(), 0);
      check("spots_drained",  exp_spot_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_writer.md
FRAME_WRITER -- requirements
Module: frame_writer

Interface
REQ-001 SHALL have parameter H_PAIRS, default 320, meaning pixel pairs per line.
REQ-002 SHALL have parameter V_LINES, default 480, meaning lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 18, meaning frame-buffer address width.
REQ-004 pclk  input  1  capture clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vsync  input  1  camera vsync, high = frame boundary/blanking.
REQ-007 href  input  1  camera href, high = active line.
REQ-008 pix_data  input  32  YCbCr422 pair {Y0,Cb,Cr,Y1}, Y0 in [31:24], Y1 in [7:0].
REQ-009 pix_done  input  1  high when pix_data holds a complete pair; may stay high several cycles.
REQ-010 threshold  input  8  minimum luma for spot candidacy.
REQ-011 bram_addr  output  ADDR_W  frame-buffer write address.
REQ-012 bram_din  output  16  {Y0,Y1} write data.
REQ-013 bram_we  output  1  one-cycle write strobe.
REQ-014 spot_x  output  10  pixel column of brightest candidate.
REQ-015 spot_y  output  9  line of brightest candidate.
REQ-016 spot_luma  output  8  luma of brightest candidate.
REQ-017 spot_found  output  1  a candidate existed in the last completed frame.
REQ-018 spot_valid  output  1  one-cycle pulse: spot_* updated.
REQ-019 frame_count  output  8  completed frames, wraps 255->0.
REQ-020 overflow  output  1  sticky: pair/line beyond H_PAIRS/V_LINES dropped.

Function
REQ-021 SHALL form pair strobe = pix_done & ~pix_done_d (pix_done_d registered); a held-high pix_done yields exactly one strobe.
REQ-022 SHALL implement FSM WAIT_SYNC -> ARMED (vsync seen high) -> CAPTURE (vsync falls) -> DONE (vsync rises) -> ARMED.
REQ-023 Strobes outside CAPTURE or with href low SHALL be ignored (no write, no spot update).
REQ-024 In CAPTURE, strobe with col < H_PAIRS and row < V_LINES SHALL produce bram_we=1 on the next cycle for exactly one cycle, bram_din={pix_data[31:24],pix_data[7:0]}, bram_addr=row*H_PAIRS+col.
REQ-025 bram_addr SHALL come from a running counter (increment per write, cleared on CAPTURE entry); no multiplier.
REQ-026 col SHALL increment per accepted strobe; on href falling edge col->0 and row increments only if col was nonzero.
REQ-027 Strobe and href falling edge sampled same cycle: write uses pre-reset col, then col->0.
REQ-028 Strobe with col >= H_PAIRS or row >= V_LINES SHALL be dropped and SHALL set overflow; address counter not advanced.
REQ-029 Per accepted strobe: candidate luma = max(Y0,Y1), x = 2*col + (Y1>Y0 ? 1 : 0) (tie -> even pixel).
REQ-030 Candidate SHALL replace running best only if luma >= threshold and luma > best luma (first occurrence wins ties).
REQ-031 DONE (one cycle) SHALL copy best to spot_x/spot_y/spot_luma, set spot_found, pulse spot_valid, increment frame_count, clear running best, row, col, address.
REQ-032 No candidate in frame: spot_x=0, spot_y=0, spot_luma=0, spot_found=0, spot_valid still pulses.
REQ-033 vsync rising in ARMED/WAIT_SYNC SHALL not pulse spot_valid; a frame must be fully bracketed by vsync.

Reset
REQ-034 reset SHALL force WAIT_SYNC, all counters 0, all outputs 0 including overflow and frame_count, pix_done_d 0.
REQ-035 reset mid-CAPTURE SHALL abandon the frame: no spot_valid, no further writes until next full vsync bracket.

Verification
REQ-036 Full frame, H_PAIRS=4, V_LINES=2, all Y=0x10, threshold=0x80 -> 8 writes, addr 0..7, spot_found=0, spot_valid once, frame_count=1.
REQ-037 pix_done held high 3 cycles once -> exactly one bram_we, addr 0.
REQ-038 Pair at row 1, col 2, Y0=0x90, Y1=0xF0, threshold=0x80 -> spot_x=5, spot_y=1, spot_luma=0xF0, spot_found=1.
REQ-039 Two pairs both Y=0xC0 at (0,0),(1,3) -> spot_x=0, spot_y=0 (first wins).
REQ-040 5 pairs in one line with H_PAIRS=4 -> 4 writes, overflow=1, stays 1 into next frame until reset.
REQ-041 reset asserted mid-line, then vsync high->low->high -> writes restart at addr 0, spot_valid only on the completed bracket.
